// File: rtl/microseq_controller_if.sv
// ----------------------------------------------------------------------------
// Module  : microseq_controller_if
// Purpose : Decode-stage bus between the pipeline and the microsequencer.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface microseq_controller_if #(
    parameter int CTRL_SIZE = 21,
    parameter int ADDR_W    = 10
);
    logic [31:0]                   instruction;
    logic                          mem_ready;
    logic                          abort;
    logic                          cs_we;
    logic [ADDR_W-1:0]             cs_waddr;
    logic [CTRL_SIZE+ADDR_W+1:0]   cs_wdata;
    logic [CTRL_SIZE-1:0]          ctrl_signals;
    logic                          busy;
    logic [ADDR_W-1:0]             upc;
    logic                          seq_err;

    modport master (
        output instruction, mem_ready, abort, cs_we, cs_waddr, cs_wdata,
        input  ctrl_signals, busy, upc, seq_err
    );

    modport slave (
        input  instruction, mem_ready, abort, cs_we, cs_waddr, cs_wdata,
        output ctrl_signals, busy, upc, seq_err
    );
endinterface

`default_nettype wire

// File: rtl/microseq_controller.sv
// ----------------------------------------------------------------------------
// Module  : microseq_controller
// Purpose : Microcoded decode sequencer with writable store, waits and watchdog.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module microseq_controller #(
    parameter int CTRL_SIZE = 21,
    parameter int ADDR_W    = 10,
    parameter int TIMEOUT   = 64
) (
    input  wire logic               clk,
    input  wire logic               rst,
    microseq_controller_if.slave    bus
);
    localparam int WORD_W = CTRL_SIZE + 2 + ADDR_W;
    localparam int CNT_W  = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] ST_DISPATCH = 2'd0;
    localparam logic [1:0] ST_SEQ      = 2'd1;
    localparam logic [1:0] ST_WAIT     = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [WORD_W-1:0]    cs_mem_q [2**ADDR_W];
    logic [1:0]           state_q, state_d;
    logic [ADDR_W-1:0]    upc_q, upc_d;
    logic [CNT_W-1:0]     seq_cnt_q, seq_cnt_d;
    logic                 seq_err_q, seq_err_d;

    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic                 use_f3;
    logic                 use_b30;
    logic [ADDR_W-1:0]    disp_addr;
    logic [ADDR_W-1:0]    act_addr;
    logic [WORD_W-1:0]    word;
    logic [CTRL_SIZE-1:0] w_ctrl;
    logic                 w_wait;
    logic                 w_cont;
    logic [ADDR_W-1:0]    w_next;
    logic                 unused_instr;

    // Store is deliberately not reset; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (bus.cs_we) begin
            cs_mem_q[bus.cs_waddr] <= bus.cs_wdata;
        end
    end

    assign opcode       = bus.instruction[6:0];
    assign func3        = bus.instruction[14:12];
    assign unused_instr = ^{bus.instruction[31], bus.instruction[29:15],
                            bus.instruction[11:7]};

    always_comb begin
        use_f3  = (opcode == 7'b0110011) || (opcode == 7'b0010011) ||
                  (opcode == 7'b0000011) || (opcode == 7'b1100111) ||
                  (opcode == 7'b0100011) || (opcode == 7'b1100011);
        use_b30 = (opcode == 7'b0110011) ||
                  ((opcode == 7'b0010011) && (func3 == 3'b101));
        disp_addr      = '0;
        disp_addr[8:4] = bus.instruction[6:2];
        if (use_f3) begin
            disp_addr[3:1] = func3;
        end
        if (use_b30) begin
            disp_addr[0] = bus.instruction[30];
        end
    end

    assign act_addr = (state_q == ST_DISPATCH) ? disp_addr : upc_q;
    assign word     = cs_mem_q[act_addr];
    assign w_ctrl   = word[WORD_W-1:ADDR_W+2];
    assign w_wait   = word[ADDR_W+1];
    assign w_cont   = word[ADDR_W];
    assign w_next   = word[ADDR_W-1:0];

    // Priority: abort, then watchdog, then the microinstruction itself.
    always_comb begin
        state_d   = ST_DISPATCH;
        upc_d     = upc_q;
        seq_err_d = seq_err_q;
        if (bus.abort) begin
            state_d = ST_DISPATCH;
        end else if ((state_q != ST_DISPATCH) && (seq_cnt_q == CNT_LAST)) begin
            state_d   = ST_DISPATCH;
            seq_err_d = 1'b1;
        end else if (w_wait && !bus.mem_ready) begin
            state_d = ST_WAIT;
            upc_d   = act_addr;
        end else if (w_cont) begin
            state_d = ST_SEQ;
            upc_d   = w_next;
        end else begin
            state_d = ST_DISPATCH;
        end
        seq_cnt_d = (state_d == ST_DISPATCH) ? '0 : seq_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_DISPATCH;
            upc_q     <= '0;
            seq_cnt_q <= '0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            upc_q     <= upc_d;
            seq_cnt_q <= seq_cnt_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign bus.busy         = !rst && (state_d != ST_DISPATCH);
    assign bus.ctrl_signals = (rst || ((state_q == ST_DISPATCH) && (bus.instruction == 32'd0)))
                              ? '0 : w_ctrl;
    assign bus.upc          = act_addr;
    assign bus.seq_err      = seq_err_q;

endmodule

`default_nettype wire

// File: tb/tb_microseq_controller.sv
// ----------------------------------------------------------------------------
// Module  : tb_microseq_controller
// Purpose : Directed self-checking bench for microseq_controller.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_microseq_controller;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_CUST = 32'h0000000B;
    localparam logic [20:0] C_A    = 21'h1AAAA;
    localparam logic [20:0] C_B    = 21'h0BBBB;
    localparam logic [20:0] C_C    = 21'h0CCCC;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    microseq_controller_if #(.CTRL_SIZE(21), .ADDR_W(10)) bus ();

    microseq_controller #(.CTRL_SIZE(21), .ADDR_W(10), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] addr, input logic [20:0] ctrl,
                      input logic wm, input logic ct, input logic [9:0] nxt);
        bus.cs_we    = 1'b1;
        bus.cs_waddr = addr;
        bus.cs_wdata = {ctrl, wm, ct, nxt};
        @(negedge clk);
        bus.cs_we    = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b1;
        bus.instruction  = '0;
        bus.mem_ready    = 1'b0;
        bus.abort        = 1'b0;
        bus.cs_we        = 1'b0;
        bus.cs_waddr     = '0;
        bus.cs_wdata     = '0;
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ctrl", 32'(bus.ctrl_signals), 32'd0);

        // Load the store while held in reset.
        wr(10'h000, 21'h1FFFF, 1'b0, 1'b0, 10'h000);
        wr(10'h0C0, 21'h00011, 1'b0, 1'b0, 10'h000);
        wr(10'h0C1, 21'h00021, 1'b0, 1'b0, 10'h000);
        wr(10'h004, 21'h000A5, 1'b1, 1'b0, 10'h000);
        wr(10'h020, C_A, 1'b0, 1'b1, 10'h200);
        wr(10'h200, C_B, 1'b0, 1'b1, 10'h201);
        wr(10'h201, C_C, 1'b0, 1'b0, 10'h000);
        rst = 1'b0;
        #1;
        chk("zero_ctrl", 32'(bus.ctrl_signals), 32'd0);
        chk("zero_upc", 32'(bus.upc), 32'd0);
        chk("zero_busy", 32'(bus.busy), 32'd0);
        chk("zero_err", 32'(bus.seq_err), 32'd0);
        @(negedge clk);

        bus.instruction = I_ADD;
        #1;
        chk("add_ctrl", 32'(bus.ctrl_signals), 32'h11);
        chk("add_upc", 32'(bus.upc), 32'h0C0);
        chk("add_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.instruction = I_SUB;
        #1;
        chk("sub_ctrl", 32'(bus.ctrl_signals), 32'h21);
        chk("sub_upc", 32'(bus.upc), 32'h0C1);
        @(negedge clk);

        // Write during a read of the same address: old word first, new word next.
        bus.instruction = I_ADD;
        bus.cs_we    = 1'b1;
        bus.cs_waddr = 10'h0C0;
        bus.cs_wdata = {21'h00033, 1'b0, 1'b0, 10'h000};
        #1;
        chk("wr_old", 32'(bus.ctrl_signals), 32'h11);
        @(negedge clk);
        bus.cs_we = 1'b0;
        #1;
        chk("wr_new", 32'(bus.ctrl_signals), 32'h33);
        @(negedge clk);

        bus.instruction = I_LW;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3);
            #1;
            chk("lw_ctrl", 32'(bus.ctrl_signals), 32'h0A5);
            chk("lw_upc", 32'(bus.upc), 32'h004);
            chk("lw_busy", 32'(bus.busy), (i < 3) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        bus.instruction = '0;
        bus.mem_ready   = 1'b0;
        #1;
        chk("lw_done_upc", 32'(bus.upc), 32'd0);
        chk("lw_done_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);

        bus.instruction = I_LW;
        bus.mem_ready   = 1'b1;
        #1;
        chk("lw_fast_busy", 32'(bus.busy), 32'd0);
        chk("lw_fast_ctrl", 32'(bus.ctrl_signals), 32'h0A5);
        @(negedge clk);
        bus.instruction = '0;
        bus.mem_ready   = 1'b0;
        #1;
        chk("lw_fast_upc", 32'(bus.upc), 32'd0);
        @(negedge clk);

        // Three-step sequence 0x020 -> 0x200 -> 0x201.
        bus.instruction = I_CUST;
        #1;
        chk("s0_upc", 32'(bus.upc), 32'h020);
        chk("s0_ctrl", 32'(bus.ctrl_signals), 32'(C_A));
        chk("s0_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        #1;
        chk("s1_upc", 32'(bus.upc), 32'h200);
        chk("s1_ctrl", 32'(bus.ctrl_signals), 32'(C_B));
        chk("s1_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        #1;
        chk("s2_upc", 32'(bus.upc), 32'h201);
        chk("s2_ctrl", 32'(bus.ctrl_signals), 32'(C_C));
        chk("s2_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);

        // Abort during the 0x200 step; the held instruction then re-dispatches.
        #1;
        chk("ab0_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.abort = 1'b1;
        #1;
        chk("ab_upc", 32'(bus.upc), 32'h200);
        chk("ab_busy", 32'(bus.busy), 32'd0);
        chk("ab_ctrl", 32'(bus.ctrl_signals), 32'(C_B));
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        chk("ab_after_upc", 32'(bus.upc), 32'h020);
        chk("ab_after_cnt", 32'(dut.seq_cnt_q), 32'd0);
        chk("ab_after_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        #1;
        chk("ab_rerun_upc", 32'(bus.upc), 32'h200);
        @(negedge clk);
        #1;
        chk("ab_rerun_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.instruction = '0;

        // Self-looping word exercises the watchdog (TIMEOUT = 8).
        wr(10'h020, C_A, 1'b0, 1'b1, 10'h020);
        bus.instruction = I_CUST;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("wd_busy", 32'(bus.busy), (i < 7) ? 32'd1 : 32'd0);
            chk("wd_err_pre", 32'(bus.seq_err), 32'd0);
            @(negedge clk);
        end
        bus.instruction = '0;
        #1;
        chk("wd_err", 32'(bus.seq_err), 32'd1);
        chk("wd_busy_end", 32'(bus.busy), 32'd0);
        chk("wd_upc_end", 32'(bus.upc), 32'd0);
        @(negedge clk);

        // Reset while waiting on memory.
        bus.instruction = I_LW;
        #1;
        chk("rw_busy0", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw_rst_busy", 32'(bus.busy), 32'd0);
        chk("rw_rst_ctrl", 32'(bus.ctrl_signals), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.instruction = '0;
        #1;
        chk("rw_busy", 32'(bus.busy), 32'd0);
        chk("rw_err", 32'(bus.seq_err), 32'd0);
        chk("rw_upc", 32'(bus.upc), 32'd0);
        @(negedge clk);

        bus.instruction = I_ADD;
        #1;
        chk("keep_add", 32'(bus.ctrl_signals), 32'h33);
        @(negedge clk);
        bus.instruction = I_SUB;
        #1;
        chk("keep_sub", 32'(bus.ctrl_signals), 32'h21);
        @(negedge clk);
        bus.instruction = I_LW;
        bus.mem_ready   = 1'b1;
        #1;
        chk("keep_lw", 32'(bus.ctrl_signals), 32'h0A5);
        chk("keep_lw_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.instruction = '0;
        bus.mem_ready   = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
